store_unit: RTL

Memory-store sequencer: the write-side counterpart of the load extraction logic. Takes a store request (word/half/byte) from the control unit and drives the data memory. Words are written directly; halfwords and bytes use a read-modify-write so untouched bytes of the addressed word are preserved. The lane convention matches the load side: a halfword occupies bits [31:16] and a byte occupies bits [31:24].

---
 rtl/store_pkg.sv | 17 +
 rtl/store_merge.sv | 24 ++
 rtl/store_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared state encoding and size codes for the store sequencer
package store_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_WR   = 2'b10,
        S_DONE = 2'b11
    } store_state_e;

    // Size codes are shared with the load extraction side.
    localparam logic [1:0] CT_WORD = 2'b00;
    localparam logic [1:0] CT_HALF = 2'b01;
    localparam logic [1:0] CT_BYTE = 2'b10;
    localparam logic [1:0] CT_RSVD = 2'b11;

endpackage

// File: rtl/store_merge.sv
// rtl/store_merge.sv - lane merge of store data into the previously read memory word
module store_merge
    import store_pkg::*;
(
    input  logic [1:0]  ct_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rd_i,
    output logic [31:0] merged_o
);

    // The top byte of the read word is always overwritten by a half or byte store.
    logic unused_rd;
    assign unused_rd = ^rd_i[31:24];

    always_comb begin
        merged_o = wd_i;
        case (ct_i)
            CT_HALF: merged_o = {wd_i[15:0], rd_i[15:0]};
            CT_BYTE: merged_o = {wd_i[7:0], rd_i[23:0]};
            default: merged_o = wd_i;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - word/half/byte store sequencer with read-modify-write; STORE_UNIT_ERR_EN enables reserved-ct abort
module store_unit
    import store_pkg::*;
#(
    parameter int MEM_RD_LAT = 1
)
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [1:0]  ct_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_wr_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int CW = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

    store_state_e   state_q;
    logic [1:0]     ct_q;
    logic [31:0]    addr_q;
    logic [31:0]    wd_q;
    logic [31:0]    rd_q;
    logic [CW-1:0]  cnt_q;
    logic           err_q;
    logic           abort_d;
    logic           rmw_d;
    logic [31:0]    mem_wdata_d;

`ifdef STORE_UNIT_ERR_EN
    assign abort_d = (ct_i == CT_RSVD);
`else
    assign abort_d = 1'b0;
`endif

    // Reserved ct falls through to a plain word write when the abort path is disabled.
    assign rmw_d = (ct_i == CT_HALF) || (ct_i == CT_BYTE);

    store_merge u_merge (
        .ct_i     (ct_q),
        .wd_i     (wd_q),
        .rd_i     (rd_q),
        .merged_o (mem_wdata_d)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            ct_q    <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        ct_q   <= ct_i;
                        addr_q <= addr_i;
                        wd_q   <= wdata_i;
                        if (abort_d) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else if (rmw_d) begin
                            cnt_q   <= CW'(MEM_RD_LAT - 1);
                            state_q <= S_RD;
                        end else begin
                            state_q <= S_WR;
                        end
                    end
                end
                S_RD: begin
                    if (cnt_q == '0) begin
                        rd_q    <= mem_rdata_i;
                        state_q <= S_WR;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_WR: begin
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode the registered state only, so reset clears them asynchronously.
    assign busy_o      = (state_q == S_RD) || (state_q == S_WR);
    assign mem_wr_o    = (state_q == S_WR);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = err_q;
    assign mem_addr_o  = (state_q == S_IDLE) ? 32'h0 : addr_q;
    assign mem_wdata_o = mem_wr_o ? mem_wdata_d : 32'h0;

endmodule
